// File: rtl/hex_display_pkg.sv
// +--------------------------------------------------------------------+
// | hex_display_pkg: segment code table and counter width helper.       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Counters and indices need at least one bit even when the range is 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_display_driver_seg7_encode.sv
// +--------------------------------------------------------------------+
// | seg7_encode: one hex digit plus dark flag to a seven-segment code.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module seg7_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dark,
  output logic [6:0] seg
);

  assign seg = dark ? SEG_BLANK : SEG_TABLE[digit];

endmodule

`default_nettype wire

// File: rtl/hex_display_driver.sv
// +--------------------------------------------------------------------+
// | hex_display_driver: latched multi-digit 7-seg driver, static+scan.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  output logic [7*NUM_DIGITS-1:0] seg_static,
  output logic [6:0]              seg_scan,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    loaded
);

  localparam int SCAN_W  = cnt_width(SCAN_DIV);
  localparam int BLINK_W = cnt_width(BLINK_DIV);
  localparam int IDX_W   = cnt_width(NUM_DIGITS);

  localparam logic [SCAN_W-1:0]  C_SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0]   r_val;
  logic [NUM_DIGITS-1:0]     r_blank;
  logic [NUM_DIGITS-1:0]     r_blink;
  logic                      r_loaded;
  logic [BLINK_W-1:0]        r_blink_cnt;
  logic                      r_blink_phase;
  logic [SCAN_W-1:0]         r_scan_cnt;
  logic [IDX_W-1:0]          r_scan_idx;
  logic [7*NUM_DIGITS-1:0]   r_seg_static;
  logic [6:0]                r_seg_scan;
  logic [NUM_DIGITS-1:0]     r_digit_sel;

  logic [NUM_DIGITS-1:0]      w_nz_from;
  logic [NUM_DIGITS-1:0]      w_dark;
  logic [NUM_DIGITS-1:0][6:0] w_code;
  logic                       w_scan_wrap;
  logic [IDX_W-1:0]           w_idx_next;
  logic [6:0]                 w_scan_code;
  logic [NUM_DIGITS-1:0]      w_sel_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_val    <= '0;
      r_blank  <= '0;
      r_blink  <= '0;
      r_loaded <= 1'b0;
    end else if (load) begin
      r_val    <= value;
      r_blank  <= blank_mask;
      r_blink  <= blink_mask;
      r_loaded <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == C_BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign w_scan_wrap = (r_scan_cnt == C_SCAN_LAST);

  always_comb begin
    w_idx_next = r_scan_idx;
    if (w_scan_wrap) begin
      w_idx_next = (r_scan_idx == C_IDX_LAST) ? '0 : r_scan_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
      r_scan_idx <= w_idx_next;
    end
  end

  // w_nz_from[i] is high when any digit at or above i is nonzero.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    w_nz_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc | (|r_val[4*i +: 4]);
      w_nz_from[i] = acc;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign w_dark[i] = ~r_loaded | r_blank[i] | (r_blink[i] & r_blink_phase);
    end else begin : g_upper
      assign w_dark[i] = ~r_loaded | r_blank[i] | (r_blink[i] & r_blink_phase)
                       | (lz_suppress & ~w_nz_from[i]);
    end

    seg7_encode u_enc (
      .digit (r_val[4*i +: 4]),
      .dark  (w_dark[i]),
      .seg   (w_code[i])
    );
  end

  // Select by the upcoming index so seg_scan and digit_sel switch together.
  always_comb begin
    w_scan_code = SEG_BLANK;
    w_sel_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_next == IDX_W'(i)) begin
        w_scan_code   = w_code[i];
        w_sel_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_seg_static <= {NUM_DIGITS{SEG_BLANK}};
      r_seg_scan   <= SEG_BLANK;
      r_digit_sel  <= NUM_DIGITS'(1);
    end else begin
      r_seg_static <= w_code;
      r_seg_scan   <= w_scan_code;
      r_digit_sel  <= w_sel_next;
    end
  end

  assign seg_static = r_seg_static;
  assign seg_scan   = r_seg_scan;
  assign digit_sel  = r_digit_sel;
  assign loaded     = r_loaded;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_driver.sv
// +--------------------------------------------------------------------+
// | tb_hex_display_driver: directed self-checking bench, 6 digits.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hex_display_driver;

  localparam int N = 6;
  localparam logic [41:0] C_ALL_BLANK = {6{7'h7F}};

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          load = 1'b0;
  logic [23:0]   value = '0;
  logic [5:0]    blank_mask = '0;
  logic [5:0]    blink_mask = '0;
  logic          lz_suppress = 1'b0;
  logic [41:0]   seg_static;
  logic [6:0]    seg_scan;
  logic [5:0]    digit_sel;
  logic          loaded;

  int n_pass  = 0;
  int n_total = 0;
  int cyc;

  hex_display_driver #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (3),
    .BLINK_DIV  (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .load        (load),
    .value       (value),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .seg_static  (seg_static),
    .seg_scan    (seg_scan),
    .digit_sel   (digit_sel),
    .loaded      (loaded)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drive_load(input logic [23:0] v, input logic [5:0] bl, input logic [5:0] bk);
    @(negedge clk);
    value = v; blank_mask = bl; blink_mask = bk; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (10) @(negedge clk);
    n_total++;
    if (seg_static !== C_ALL_BLANK) $display("FAIL reset_seg_static got=%h exp=%h", seg_static, C_ALL_BLANK);
    else n_pass++;
    n_total++;
    if (loaded !== 1'b0) $display("FAIL reset_loaded got=%b exp=0", loaded);
    else n_pass++;
    n_total++;
    if (seg_scan !== 7'h7F) $display("FAIL reset_seg_scan got=%h exp=7f", seg_scan);
    else n_pass++;
    n_total++;
    if (digit_sel !== 6'b000001 && digit_sel !== 6'b000010 && digit_sel !== 6'b000100
        && digit_sel !== 6'b001000 && digit_sel !== 6'b010000 && digit_sel !== 6'b100000)
      $display("FAIL reset_idle_sel_onehot got=%b", digit_sel);
    else n_pass++;
  endtask

  task automatic test_static();
    logic [41:0] exp;
    exp = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E};
    drive_load(24'h0123AF, 6'b0, 6'b0);
    n_total++;
    if (loaded !== 1'b1) $display("FAIL static_loaded got=%b exp=1", loaded);
    else n_pass++;
    n_total++;
    if (seg_static !== C_ALL_BLANK) $display("FAIL static_latency got=%h exp=%h", seg_static, C_ALL_BLANK);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (seg_static !== exp) $display("FAIL static_value got=%h exp=%h", seg_static, exp);
    else n_pass++;
  endtask

  task automatic test_lz();
    logic [41:0] exp;
    @(negedge clk);
    lz_suppress = 1'b1;
    @(negedge clk);
    exp = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E};
    n_total++;
    if (seg_static !== exp) $display("FAIL lz_msd got=%h exp=%h", seg_static, exp);
    else n_pass++;
    drive_load(24'h000000, 6'b0, 6'b0);
    @(negedge clk);
    exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    n_total++;
    if (seg_static !== exp) $display("FAIL lz_all_zero got=%h exp=%h", seg_static, exp);
    else n_pass++;
    drive_load(24'h000100, 6'b0, 6'b0);
    @(negedge clk);
    exp = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
    n_total++;
    if (seg_static !== exp) $display("FAIL lz_inner_zero got=%h exp=%h", seg_static, exp);
    else n_pass++;
    lz_suppress = 1'b0;
  endtask

  task automatic test_blank();
    logic [41:0] exp;
    drive_load(24'h0123AF, 6'b000100, 6'b0);
    @(negedge clk);
    exp = {7'h40, 7'h79, 7'h24, 7'h7F, 7'h08, 7'h0E};
    n_total++;
    if (seg_static !== exp) $display("FAIL blank_digit2 got=%h exp=%h", seg_static, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [41:0] exp_a, exp_b;
    exp_a = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79};
    exp_b = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h24};
    @(negedge clk);
    value = 24'h000001; blank_mask = '0; blink_mask = '0; load = 1'b1;
    @(negedge clk);
    value = 24'h000002;
    @(negedge clk);
    load = 1'b0;
    n_total++;
    if (seg_static !== exp_a) $display("FAIL b2b_first got=%h exp=%h", seg_static, exp_a);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (seg_static !== exp_b) $display("FAIL b2b_second got=%h exp=%h", seg_static, exp_b);
    else n_pass++;
  endtask

  task automatic test_blink();
    logic [41:0] exp;
    apply_reset();
    value = 24'h0123AF; blank_mask = '0; blink_mask = 6'b000001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      // Output after edge k shows the phase left by edge k-1.
      exp = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08,
             ((((cyc - 1) / 4) % 2) == 1) ? 7'h7F : 7'h0E};
      n_total++;
      if (seg_static !== exp) $display("FAIL blink_cyc%0d got=%h exp=%h", cyc, seg_static, exp);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    logic [6:0] codes [6];
    logic [5:0] exp_sel;
    int         idx;
    codes[0] = 7'h40; codes[1] = 7'h79; codes[2] = 7'h24;
    codes[3] = 7'h30; codes[4] = 7'h19; codes[5] = 7'h12;
    apply_reset();
    value = 24'h543210; blank_mask = '0; blink_mask = '0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      idx     = (cyc / 3) % 6;
      exp_sel = 6'b000001 << idx;
      n_total++;
      if (digit_sel !== exp_sel) $display("FAIL scan_sel_cyc%0d got=%b exp=%b", cyc, digit_sel, exp_sel);
      else n_pass++;
      n_total++;
      if (seg_scan !== codes[idx]) $display("FAIL scan_seg_cyc%0d got=%h exp=%h", cyc, seg_scan, codes[idx]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int s = 0; s < 40 && !found; s++) begin
      @(negedge clk);
      if (digit_sel === 6'b001000) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL resetmid_wait_digit3 got=%b exp=001000", digit_sel);
    else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_total++;
    if (seg_static !== C_ALL_BLANK) $display("FAIL resetmid_seg_static got=%h exp=%h", seg_static, C_ALL_BLANK);
    else n_pass++;
    n_total++;
    if (seg_scan !== 7'h7F) $display("FAIL resetmid_seg_scan got=%h exp=7f", seg_scan);
    else n_pass++;
    n_total++;
    if (digit_sel !== 6'b000001) $display("FAIL resetmid_sel got=%b exp=000001", digit_sel);
    else n_pass++;
    n_total++;
    if (loaded !== 1'b0) $display("FAIL resetmid_loaded got=%b exp=0", loaded);
    else n_pass++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    n_total++;
    if (seg_static !== C_ALL_BLANK) $display("FAIL postreset_blank got=%h exp=%h", seg_static, C_ALL_BLANK);
    else n_pass++;
    n_total++;
    if (loaded !== 1'b0) $display("FAIL postreset_loaded got=%b exp=0", loaded);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_static();
    test_lz();
    test_blank();
    test_back_to_back();
    test_blink();
    test_scan();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
